// File: rtl/uart_pkg.sv
// Shared types and frame-format helpers for the UART transmitter
// (and the receiver planned to reuse them).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  // data_bits code 0..3 selects 5..8 data bits
  function automatic logic [3:0] data_len(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] code);
    return 8'hFF >> (2'd3 - code);
  endfunction

  // Code 3 is reserved and behaves like "no parity"
  function automatic parity_e parity_decode(input logic [1:0] code);
    case (code)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/tx_uart_cfg.sv
// UART transmitter with TX FIFO and per-frame format (5-8 data bits,
// none/even/odd parity, 1 or 2 stop bits); format is latched at each pop.
module tx_uart_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          valid,
  input  logic [7:0]                    tx_data,
  output logic                          ready,
  input  logic [DIV_WIDTH-1:0]          div,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity,
  input  logic                          two_stop,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e            state_q;
  parity_e              par_q;
  logic                 tx_out_q, en_q, two_stop_q, stop_idx_q;
  logic [DIV_WIDTH-1:0] cnt_q, div_lat_q, div_eff_d;
  logic [2:0]           bit_idx_q, last_idx_q;
  logic [7:0]           shreg_q, fifo_dout;
  logic [LW-1:0]        fifo_level;
  logic                 fifo_full, fifo_empty;
  logic                 push_d, pop_d, sym_end_d, stop_done_d, line_d;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_d),
    .pop    (pop_d),
    .din    (tx_data),
    .dout   (fifo_dout),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // ready stays low through reset and rises on the first cycle after it
  assign ready       = en_q && !fifo_full;
  assign push_d      = valid && ready;
  assign sym_end_d   = (cnt_q == '0);
  assign stop_done_d = sym_end_d && (!two_stop_q || stop_idx_q);
  assign pop_d       = !fifo_empty &&
                       ((state_q == ST_IDLE) || (state_q == ST_STOP && stop_done_d));
  assign div_eff_d   = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign tx_out      = tx_out_q;
  assign level       = fifo_level;

  // shreg_q is masked at load, so its XOR covers exactly the sent bits
  always_comb begin
    line_d = 1'b1;
    case (state_q)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shreg_q[bit_idx_q];
      ST_PARITY: line_d = (^shreg_q) ^ (par_q == PAR_ODD);
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      tx_out_q   <= 1'b1;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      en_q     <= 1'b1;
      tx_out_q <= line_d;
      if (pop_d) begin
        shreg_q    <= fifo_dout & data_mask(data_bits);
        last_idx_q <= 3'(data_len(data_bits) - 4'd1);
        par_q      <= parity_decode(parity);
        two_stop_q <= two_stop;
        div_lat_q  <= div_eff_d;
        cnt_q      <= div_eff_d - DIV_WIDTH'(1);
        state_q    <= ST_START;
      end else if (state_q != ST_IDLE) begin
        if (!sym_end_d) begin
          cnt_q <= cnt_q - DIV_WIDTH'(1);
        end else begin
          cnt_q <= div_lat_q - DIV_WIDTH'(1);
          case (state_q)
            ST_START: begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end
            ST_DATA: begin
              if (bit_idx_q == last_idx_q) begin
                state_q    <= (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                stop_idx_q <= 1'b0;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
            ST_PARITY: begin
              state_q    <= ST_STOP;
              stop_idx_q <= 1'b0;
            end
            ST_STOP: begin
              if (stop_done_d) state_q <= ST_IDLE;
              else             stop_idx_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_uart_cfg.sv
// Directed bench for tx_uart_cfg: frame-format table plus FIFO-fill,
// mid-frame config change and mid-frame reset sequences.
module tb_tx_uart_cfg;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        ready;
  logic [15:0] div = 16'd4;
  logic [1:0]  data_bits = 2'd3;
  logic [1:0]  parity = 2'd0;
  logic        two_stop = 1'b0;
  logic        tx_out, busy;
  logic [4:0]  level;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tx_uart_cfg #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .tx_data   (tx_data),
    .ready     (ready),
    .div       (div),
    .data_bits (data_bits),
    .parity    (parity),
    .two_stop  (two_stop),
    .tx_out    (tx_out),
    .busy      (busy),
    .level     (level)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  dbits;
    logic [1:0]  par;
    logic        two;
    logic [15:0] dv;
    int          symw;
    logic [11:0] bits;
    int          len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference line level t cycles into a frame with symbol width w
  function automatic logic exp_bit(input logic [7:0] d, input int nb, input int par,
                                   input int w, input int t);
    int s;
    logic p;
    s = t / w;
    if (s == 0) return 1'b0;
    if (s <= nb) return d[s-1];
    if (par != 0 && s == nb + 1) begin
      p = 1'b0;
      for (int i = 0; i < nb; i++) p ^= d[i];
      return (par == 2) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tx_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    data_bits = v.dbits; parity = v.par; two_stop = v.two; div = v.dv;
    tx_data = v.data; valid = 1'b1;
    cyc();
    valid = 1'b0;
    chk($sformatf("vec%0d_level_push", idx), 32'(level), 32'd1);
    cyc();
    chk($sformatf("vec%0d_pre_start", idx), 32'(tx_out), 32'd1);
    for (int c = 0; c < v.len; c++) begin
      cyc();
      chk($sformatf("vec%0d_bit_c%0d", idx, c), 32'(tx_out), 32'(v.bits[c / v.symw]));
      chk($sformatf("vec%0d_busy_c%0d", idx, c), 32'(busy), 32'(c < v.len - 1));
    end
    cyc();
    chk($sformatf("vec%0d_end_tx", idx), 32'(tx_out), 32'd1);
    chk($sformatf("vec%0d_end_level", idx), 32'(level), 32'd0);
  endtask

  task automatic test_fill();
    logic [7:0] acc[$];
    bit ok, checked;
    int errs;
    checked = 1'b0;
    data_bits = 2'd3; parity = 2'd0; two_stop = 1'b0; div = 16'd8;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          valid = 1'b1;
          tx_data = 8'(8'h10 + i);
          if (ready) acc.push_back(tx_data);
          cyc();
          if (acc.size() == 17 && !checked) begin
            checked = 1'b1;
            chk("fill_ready_after17", 32'(ready), 32'd0);
            chk("fill_level_after17", 32'(level), 32'd16);
          end
        end
        valid = 1'b0;
      end
      begin
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
          @(negedge clk);
          if (tx_out === 1'b0) ok = 1'b1;
        end
        chk("fill_start_seen", 32'(ok), 32'd1);
        errs = 0;
        if (ok) begin
          for (int t = 0; t < 17 * 80; t++) begin
            if (t > 0) @(negedge clk);
            if (tx_out !== exp_bit(acc[t / 80], 8, 0, 8, t % 80)) errs++;
            if (busy !== (t < 17 * 80 - 1)) errs++;
          end
        end
        chk("fill_stream_errs", 32'(errs), 32'd0);
        @(negedge clk);
        chk("fill_end_tx", 32'(tx_out), 32'd1);
        chk("fill_end_busy", 32'(busy), 32'd0);
      end
    join
    chk("fill_accepted", 32'(acc.size()), 32'd17);
    chk("fill_end_level", 32'(level), 32'd0);
  endtask

  task automatic test_cfg_change();
    bit ok;
    int errs;
    logic e;
    data_bits = 2'd3; parity = 2'd0; two_stop = 1'b0; div = 16'd4;
    valid = 1'b1; tx_data = 8'h5A;
    cyc();
    tx_data = 8'hC3;
    cyc();
    valid = 1'b0;
    wait_start(ok);
    chk("cfg_start_seen", 32'(ok), 32'd1);
    errs = 0;
    if (ok) begin
      for (int t = 0; t < 40 + 66; t++) begin
        if (t > 0) cyc();
        if (t == 10) begin
          parity = 2'd1;
          div = 16'd6;
        end
        e = (t < 40) ? exp_bit(8'h5A, 8, 0, 4, t) : exp_bit(8'hC3, 8, 1, 6, t - 40);
        if (tx_out !== e) errs++;
      end
    end
    chk("cfg_stream_errs", 32'(errs), 32'd0);
    cyc();
    chk("cfg_end_tx", 32'(tx_out), 32'd1);
    chk("cfg_end_busy", 32'(busy), 32'd0);
    parity = 2'd0; div = 16'd4;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int errs;
    data_bits = 2'd3; parity = 2'd0; two_stop = 1'b0; div = 16'd4;
    valid = 1'b1;
    tx_data = 8'h11; cyc();
    tx_data = 8'h22; cyc();
    tx_data = 8'h33; cyc();
    valid = 1'b0;
    wait_start(ok);
    chk("rst_start_seen", 32'(ok), 32'd1);
    // frame 2 starts at t=40; t=50 sits inside its data bits
    for (int t = 1; t <= 50; t++) cyc();
    chk("rst_busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    cyc();
    chk("rst_tx_next_edge", 32'(tx_out), 32'd1);
    chk("rst_level_next_edge", 32'(level), 32'd0);
    chk("rst_busy_next_edge", 32'(busy), 32'd0);
    chk("rst_ready_in_reset", 32'(ready), 32'd0);
    resetn = 1'b1;
    errs = 0;
    for (int t = 0; t < 200; t++) begin
      cyc();
      if (tx_out !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("rst_quiet_errs", 32'(errs), 32'd0);
    chk("rst_ready_after", 32'(ready), 32'd1);
    chk("rst_level_after", 32'(level), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t exceeded limit 400000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //           data   dbits par   two   div    symw bits     len
    vecs[0] = '{8'h55, 2'd3, 2'd0, 1'b0, 16'd4, 4, 12'h2AA, 40};  // 8N1
    vecs[1] = '{8'h41, 2'd2, 2'd1, 1'b1, 16'd3, 3, 12'h682, 33};  // 7E2
    vecs[2] = '{8'h41, 2'd2, 2'd2, 1'b1, 16'd3, 3, 12'h782, 33};  // 7O2
    vecs[3] = '{8'hFF, 2'd0, 2'd0, 1'b0, 16'd2, 2, 12'h07E, 14};  // 5N1
    vecs[4] = '{8'h2C, 2'd1, 2'd1, 1'b0, 16'd1, 2, 12'h1D8, 18};  // 6E1, div 1 -> 2
    vecs[5] = '{8'hA3, 2'd3, 2'd3, 1'b1, 16'd0, 2, 12'h746, 22};  // 8N2, par 3, div 0 -> 2

    resetn = 1'b0;
    repeat (3) cyc();
    chk("reset_tx", 32'(tx_out), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    resetn = 1'b1;
    cyc();
    chk("post_reset_ready", 32'(ready), 32'd1);
    chk("post_reset_tx", 32'(tx_out), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(i);

    test_fill();
    repeat (2) cyc();
    test_cfg_change();
    repeat (2) cyc();
    test_mid_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_uart_cfg.md
Name: tx_uart_cfg

Overview:
- Next-generation UART transmitter with a parametrised TX FIFO and runtime frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Sits behind the SoC UART register block. The CPU pushes bytes through a valid/ready handshake; the block serialises them LSB-first onto tx_out.
- Each symbol lasts exactly div cycles. Frames stream back-to-back with no idle gap while the FIFO holds data.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥2.
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset: one clock; reset is synchronous and active-low.
- valid  in  1  write request for tx_data.
- tx_data  in  8  byte to send; bits above data_bits are ignored.
- ready  out  1  FIFO not full; a write is accepted on the edge where valid && ready.
- div  in  DIV_WIDTH  clk cycles per symbol (SYSTEM_CYCLES/BAUDRATE).
- data_bits  in  2  data length: 0→5, 1→6, 2→7, 3→8.
- parity  in  2  0 none, 1 even, 2 odd, 3 treated as none.
- two_stop  in  1  0: one stop bit; 1: two stop bits.
- tx_out  out  1  serial line, idles high.
- busy  out  1  shifter not IDLE or FIFO not empty.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: tx_out=1, busy=0, level=0, ready=0 during reset and 1 on the first cycle after resetn rises. FSM=IDLE, FIFO pointers=0.
- Reset asserted mid-frame: tx_out=1 on the next edge; FIFO contents are discarded and the frame is aborted.
- FIFO accept rule: push iff valid && level<FIFO_DEPTH. Pops on the same edge do not free a slot for a same-cycle push; ready depends only on level.
- Overflow cannot occur. Writes while ready=0 are dropped and never reach tx_out.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with FIFO non-empty: pop the head into the shift register. On that same edge, latch div, data_bits, parity and two_stop, then go to START.
- Config or div changes mid-frame affect only the next frame.
- Latency: a byte accepted into an empty FIFO with the shifter IDLE at edge N is popped at edge N+1; tx_out=0 (start bit) from edge N+2.
- Symbol timing: baud counter loads div_lat-1 on entering each symbol and decrements each clk; the symbol ends when the counter reaches 0.
- div values 0 and 1 are treated as 2.
- START: drives 0 for one symbol, then DATA with bit_idx=0.
- DATA: drives shreg[bit_idx]. After bit data_bits-1 go to PARITY if parity is enabled, else STOP.
- PARITY: drives XOR of the sent data bits for even parity, its inverse for odd. Lasts one symbol.
- STOP: drives 1 for one symbol, or two if two_stop.
- STOP end with FIFO non-empty: pop and go to START on the same edge, so there is no extra idle cycle. With FIFO empty: go to IDLE.
- Frame length in clk cycles: div × (1 + N + P + S).
- busy falls on the edge where STOP ends and the FIFO is empty.
- level counts ±1 per push/pop; a simultaneous push and pop leaves it unchanged. FIFO pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package uart_pkg:
  - FSM state enum tx_state_e.
  - Parity enum parity_e (PAR_NONE, PAR_EVEN, PAR_ODD).
  - Function mapping the data_bits code to a bit count.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH) providing push, pop, dout, level, full, empty. It is reusable by the planned RX successor.

Test Plan:
- 8N1, div=4, write 0x55: tx_out low at N+2. Sequence 0,1,0,1,0,1,0,1,0,1, 4 cycles each (40 cycles total). busy drops after the stop symbol.
- 7E2, div=3, write 0x41: start, bits 1,0,0,0,0,0,1, parity 0, two stop bits = 33 cycles. Repeat with 7O2: parity bit 1.
- 5N1, div=2, write 0xFF: only 5 data ones are sent; frame is 14 cycles. Upper bits are ignored.
- FIFO_DEPTH=16, div=8, valid held high for 20 cycles from an idle start: exactly 17 bytes accepted. ready=0 from the cycle after the 17th accept while level=16. All 17 frames are transmitted back-to-back with no idle cycles between stop and start.
- Change parity 0→1 and div 4→6 during a frame's DATA phase: the current frame is unchanged. The next frame uses 6-cycle symbols with a parity bit.
- Assert resetn=0 for 1 cycle during the DATA of the 2nd of 3 queued bytes: tx_out=1 and level=0 next edge. No further frames are sent and busy=0.
